// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues {func, operand, last} ops and sequences them into the ALU,
// returning the final accumulator value through a valid/ready result port.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset_b,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_func,
    input  logic [3:0]       op_data,
    input  logic             op_last,
    output logic [1:0]       alu_func,
    output logic [3:0]       alu_data,
    output logic             alu_clr,
    input  logic [7:0]       alu_result,
    output logic             res_valid,
    output logic [7:0]       res_data,
    output logic [CNT_W-1:0] res_count,
    input  logic             res_ready,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    logic [2:0]       state;
    logic [6:0]       mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic [CNT_W-1:0] count;
    logic [6:0]       head;
    logic             empty, full, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = wp == rp;
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head      = mem[rp[AW-1:0]];
    assign push      = op_valid && !full;
    assign pop       = (state == EXEC) && !empty;
    assign op_ready  = !full;
    assign busy      = state != IDLE;
    assign alu_clr   = state == CLEAR;
    assign res_valid = state == RESULT;
    assign alu_func  = pop ? head[6:5] : 2'b11;
    assign alu_data  = pop ? head[4:1] : 4'd0;

    always_ff @(posedge Clock) begin
        if (push) mem[wp[AW-1:0]] <= {op_func, op_data, op_last};
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            res_data  <= '0;
            res_count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            case (state)
                // A push seen in IDLE starts CLEAR next cycle so the op is poppable right after.
                IDLE: if (!empty || push) state <= CLEAR;
                CLEAR: begin
                    count <= '0;
                    state <= EXEC;
                end
                EXEC: if (pop) begin
                    count <= &count ? count : count + 1'b1;
                    if (head[0]) state <= SETTLE;
                end
                // The ALU register holds the last op's result one cycle after the pop.
                SETTLE: begin
                    res_data  <= alu_result;
                    res_count <= count;
                    state     <= RESULT;
                end
                RESULT: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scenarios against an 8-bit accumulator ALU model.
module tb_alu_op_sequencer;
    logic       Clock = 1'b0;
    logic       Reset_b = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [1:0] op_func = 2'b11;
    logic [3:0] op_data = 4'd0;
    logic       op_last = 1'b0;
    logic [1:0] alu_func;
    logic [3:0] alu_data;
    logic       alu_clr;
    logic [7:0] acc;
    logic       res_valid;
    logic [7:0] res_data;
    logic [3:0] res_count;
    logic       res_ready = 1'b0;
    logic       busy;
    int         n_checks = 0;
    int         n_fail = 0;

    alu_op_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
        .Clock(Clock), .Reset_b(Reset_b), .op_valid(op_valid), .op_ready(op_ready),
        .op_func(op_func), .op_data(op_data), .op_last(op_last), .alu_func(alu_func),
        .alu_data(alu_data), .alu_clr(alu_clr), .alu_result(acc), .res_valid(res_valid),
        .res_data(res_data), .res_count(res_count), .res_ready(res_ready), .busy(busy)
    );

    always #5 Clock = ~Clock;

    // ALU datapath: add/mul use only acc[4:0]; results truncated to 8 bits.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) acc <= 8'd0;
        else if (alu_clr) acc <= 8'd0;
        else if (alu_func == 2'b00) acc <= 8'(alu_data) + 8'(acc[4:0]);
        else if (alu_func == 2'b01) acc <= 8'(alu_data) * 8'(acc[4:0]);
        else if (alu_func == 2'b10) acc <= acc << alu_data;
    end

    task automatic send(input logic [1:0] f, input logic [3:0] d, input logic l);
        op_valid = 1'b1; op_func = f; op_data = d; op_last = l;
        @(negedge Clock);
        op_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (res_valid) begin ok = 1'b1; break; end
            @(negedge Clock);
        end
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        @(negedge Clock);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        Reset_b = 1'b0;
        @(negedge Clock);
        n_checks++;
        if ({op_ready, alu_func, alu_data, alu_clr, res_valid, res_data, res_count, busy} !== {1'b1, 2'b11, 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b f=%b d=%0d clr=%b v=%b data=%0d cnt=%0d busy=%b want 1 11 0 0 0 0 0 0",
                     op_ready, alu_func, alu_data, alu_clr, res_valid, res_data, res_count, busy);
        end
        Reset_b = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_basic;
        send(2'b00, 4'd3, 1'b0);
        n_checks++;
        if (alu_clr !== 1'b1) begin n_fail++; $display("FAIL basic_clr got %b want 1", alu_clr); end
        send(2'b00, 4'd5, 1'b1);
        n_checks++;
        if ({alu_clr, alu_func, alu_data} !== {1'b0, 2'b00, 4'd3}) begin
            n_fail++; $display("FAIL basic_exec1 got clr=%b f=%b d=%0d want 0 00 3", alu_clr, alu_func, alu_data);
        end
        @(negedge Clock);
        n_checks++;
        if ({alu_func, alu_data} !== {2'b00, 4'd5}) begin
            n_fail++; $display("FAIL basic_exec2 got f=%b d=%0d want 00 5", alu_func, alu_data);
        end
        @(negedge Clock);
        n_checks++;
        if ({res_valid, busy, alu_func} !== {1'b0, 1'b1, 2'b11}) begin
            n_fail++; $display("FAIL basic_settle got v=%b busy=%b f=%b want 0 1 11", res_valid, busy, alu_func);
        end
        @(negedge Clock);
        n_checks++;
        if ({res_valid, res_data, res_count} !== {1'b1, 8'd8, 4'd2}) begin
            n_fail++; $display("FAIL basic_result got v=%b data=%0d cnt=%0d want 1 8 2", res_valid, res_data, res_count);
        end
        handshake();
        n_checks++;
        if ({res_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL basic_idle got v=%b busy=%b want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_chain;
        bit ok;
        send(2'b00, 4'd3, 1'b0);
        send(2'b01, 4'd4, 1'b0);
        send(2'b10, 4'd1, 1'b1);
        wait_res(ok);
        n_checks++;
        if ({ok, res_data, res_count} !== {1'b1, 8'd24, 4'd3}) begin
            n_fail++; $display("FAIL chain_result got ok=%b data=%0d cnt=%0d want 1 24 3", ok, res_data, res_count);
        end
        handshake();
        send(2'b00, 4'd2, 1'b1);
        n_checks++;
        if (alu_clr !== 1'b1) begin n_fail++; $display("FAIL chain_clr got %b want 1", alu_clr); end
        wait_res(ok);
        n_checks++;
        if ({ok, res_data, res_count} !== {1'b1, 8'd2, 4'd1}) begin
            n_fail++; $display("FAIL chain_fresh got ok=%b data=%0d cnt=%0d want 1 2 1", ok, res_data, res_count);
        end
        handshake();
    endtask

    task automatic test_trunc;
        bit ok;
        for (int i = 0; i < 4; i++) send(2'b00, 4'd15, i == 3);
        wait_res(ok);
        n_checks++;
        if ({ok, res_data, res_count} !== {1'b1, 8'd28, 4'd4}) begin
            n_fail++; $display("FAIL trunc_result got ok=%b data=%0d cnt=%0d want 1 28 4", ok, res_data, res_count);
        end
        handshake();
    endtask

    task automatic test_stall;
        bit ok;
        send(2'b00, 4'd7, 1'b0);
        @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            n_checks++;
            if ({alu_func, alu_data, busy, res_valid} !== {2'b11, 4'd0, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL stall_%0d got f=%b d=%0d busy=%b v=%b want 11 0 1 0", i, alu_func, alu_data, busy, res_valid);
            end
        end
        send(2'b00, 4'd1, 1'b1);
        wait_res(ok);
        n_checks++;
        if ({ok, res_data, res_count} !== {1'b1, 8'd8, 4'd2}) begin
            n_fail++; $display("FAIL stall_result got ok=%b data=%0d cnt=%0d want 1 8 2", ok, res_data, res_count);
        end
        handshake();
    endtask

    task automatic test_full;
        bit ok;
        send(2'b00, 4'd1, 1'b1);
        wait_res(ok);
        send(2'b00, 4'd1, 1'b0);
        send(2'b01, 4'd3, 1'b0);
        send(2'b10, 4'd1, 1'b0);
        send(2'b00, 4'd4, 1'b1);
        n_checks++;
        if ({ok, op_ready} !== 2'b10) begin
            n_fail++; $display("FAIL full_ready got ok=%b rdy=%b want 1 0", ok, op_ready);
        end
        // Offered while full: must be dropped.
        op_valid = 1'b1; op_func = 2'b00; op_data = 4'd9; op_last = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            n_checks++;
            if ({res_valid, res_data, res_count, op_ready} !== {1'b1, 8'd1, 4'd1, 1'b0}) begin
                n_fail++; $display("FAIL full_hold_%0d got v=%b data=%0d cnt=%0d rdy=%b want 1 1 1 0", i, res_valid, res_data, res_count, op_ready);
            end
        end
        op_valid = 1'b0;
        handshake();
        wait_res(ok);
        n_checks++;
        if ({ok, res_data, res_count} !== {1'b1, 8'd10, 4'd4}) begin
            n_fail++; $display("FAIL full_order got ok=%b data=%0d cnt=%0d want 1 10 4", ok, res_data, res_count);
        end
        handshake();
        repeat (3) @(negedge Clock);
        n_checks++;
        if ({busy, op_ready} !== 2'b01) begin
            n_fail++; $display("FAIL full_drop got busy=%b rdy=%b want 0 1", busy, op_ready);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        send(2'b00, 4'd5, 1'b0);
        send(2'b00, 4'd5, 1'b0);
        send(2'b00, 4'd5, 1'b1);
        #2 Reset_b = 1'b0;
        #1;
        n_checks++;
        if ({op_ready, alu_func, alu_data, alu_clr, res_valid, res_data, res_count, busy} !== {1'b1, 2'b11, 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_outputs got rdy=%b f=%b d=%0d clr=%b v=%b data=%0d cnt=%0d busy=%b want 1 11 0 0 0 0 0 0",
                     op_ready, alu_func, alu_data, alu_clr, res_valid, res_data, res_count, busy);
        end
        @(negedge Clock);
        Reset_b = 1'b1;
        repeat (3) @(negedge Clock);
        n_checks++;
        if ({busy, op_ready} !== 2'b01) begin
            n_fail++; $display("FAIL midreset_empty got busy=%b rdy=%b want 0 1", busy, op_ready);
        end
        send(2'b00, 4'd6, 1'b1);
        n_checks++;
        if (alu_clr !== 1'b1) begin n_fail++; $display("FAIL single_clr got %b want 1", alu_clr); end
        @(negedge Clock);
        n_checks++;
        if ({alu_func, alu_data} !== {2'b00, 4'd6}) begin
            n_fail++; $display("FAIL single_exec got f=%b d=%0d want 00 6", alu_func, alu_data);
        end
        @(negedge Clock);
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_settle got v=%b want 0", res_valid); end
        @(negedge Clock);
        n_checks++;
        if ({res_valid, res_data, res_count} !== {1'b1, 8'd6, 4'd1}) begin
            n_fail++; $display("FAIL single_result got v=%b data=%0d cnt=%0d want 1 6 1", res_valid, res_data, res_count);
        end
        handshake();
        wait_res(ok);
        n_checks++;
        if (ok !== 1'b0) begin n_fail++; $display("FAIL single_stray got res_valid=%b want 0", ok); end
    endtask

    task automatic test_saturate;
        bit ok;
        for (int i = 0; i < 16; i++) send(2'b11, 4'd0, 1'b0);
        send(2'b00, 4'd1, 1'b1);
        wait_res(ok);
        n_checks++;
        if ({ok, res_data, res_count} !== {1'b1, 8'd1, 4'd15}) begin
            n_fail++; $display("FAIL saturate got ok=%b data=%0d cnt=%0d want 1 1 15", ok, res_data, res_count);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_trunc();
        test_stall();
        test_full();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
